// File: rtl/t_sequencer_6502.sv
// rtl/t_sequencer_6502.sv - 6502 timing-state and interrupt sequencer
//
// Owns the one-hot T-state register and the SD1/SD2 special cycles. It also
// latches reset, NMI and IRQ requests and tells the decoder when to inject
// a BRK sequence.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   READY           1 = advance sequencing state this cycle
//   NEXT_T          decoder: next cycle is T0
//   CLEAR_T         decoder: enter SD1 (RMW special cycles)
//   I_FLAG          PSR I bit, masks IRQs
//   NMI_n           asynchronous NMI pin, falling-edge triggered
//   IRQ_n, IRQ_EN   per-channel active-low IRQ pins and enables
//   VEC_ACK         BRK sequence has fetched its vector
//   T_state         one-hot timing state, all-zero during SD1/SD2
//   SD1, SD2        special cycles
//   SYNC            opcode-fetch cycle
//   INJECT          decoder substitutes BRK for the fetched opcode
//   RESET_req, NMI_req, IRQ_req   active-low pending requests
//   IRQ_ID          lowest-index asserted enabled IRQ channel
module t_sequencer_6502 #(
    parameter int T_DEPTH  = 6,
    parameter int IRQ_CH   = 1,
    parameter int NMI_SYNC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                READY,
    input  logic                NEXT_T,
    input  logic                CLEAR_T,
    input  logic                I_FLAG,
    input  logic                NMI_n,
    input  logic [IRQ_CH-1:0]   IRQ_n,
    input  logic [IRQ_CH-1:0]   IRQ_EN,
    input  logic                VEC_ACK,
    output logic [T_DEPTH-1:0]  T_state,
    output logic                SD1,
    output logic                SD2,
    output logic                SYNC,
    output logic                INJECT,
    output logic                RESET_req,
    output logic                NMI_req,
    output logic                IRQ_req,
    output logic [2:0]          IRQ_ID
);

    logic [T_DEPTH-1:0]  r_t;
    logic                r_sd1;
    logic                r_sd2;
    logic                r_inject;
    logic                r_reset_req;
    logic                r_nmi_req;
    logic                r_irq_req;
    logic [2:0]          r_irq_id;
    logic [NMI_SYNC-1:0] r_nmi_sync;
    logic                r_nmi_last;
    logic [IRQ_CH-1:0]   r_irq_s1;
    logic [IRQ_CH-1:0]   r_irq_s2;

    logic [T_DEPTH-1:0]  w_t_nxt;
    logic                w_sd1_nxt;
    logic                w_sd2_nxt;
    logic                w_legal;
    logic                w_t0_to_t1;
    logic                w_nmi_fall;
    logic                w_ack_rst;
    logic                w_ack_nmi;
    logic                w_pending;
    logic [IRQ_CH-1:0]   w_irq_act;
    logic [2:0]          w_irq_id;

    // Exactly one of the T bits, SD1, SD2 may be set; anything else
    // recovers to T0 on the next advance.
    assign w_legal = ($countones({r_t, r_sd1, r_sd2}) == 1);

    always_comb begin
        w_t_nxt   = '0;
        w_sd1_nxt = 1'b0;
        w_sd2_nxt = 1'b0;
        if (!w_legal)                w_t_nxt[0] = 1'b1;
        else if (r_sd1)              w_sd2_nxt  = 1'b1;
        else if (r_sd2)              w_t_nxt[0] = 1'b1;
        else if (CLEAR_T)            w_sd1_nxt  = 1'b1;
        else if (NEXT_T)             w_t_nxt[0] = 1'b1;
        else if (r_t[T_DEPTH-1])     w_sd1_nxt  = 1'b1;
        else                         w_t_nxt    = r_t << 1;
    end

    assign w_t0_to_t1 = w_legal & r_t[0] & ~CLEAR_T & ~NEXT_T;

    // Falling edge is taken from the synchroniser output against its
    // previous value, so metastability never reaches the pending flop.
    assign w_nmi_fall = r_nmi_last & ~r_nmi_sync[NMI_SYNC-1];

    // One acknowledge clears exactly one source: reset first, then NMI.
    // IRQ has no pending flop; it clears when the source lets go.
    assign w_ack_rst = VEC_ACK & ~r_reset_req;
    assign w_ack_nmi = VEC_ACK & r_reset_req & ~r_nmi_req;

    assign w_pending = ~r_reset_req | ~r_nmi_req | ~r_irq_req;

    assign w_irq_act = ~r_irq_s2 & IRQ_EN;

    // Scan from the top down so the lowest asserted index is the last write.
    always_comb begin
        w_irq_id = 3'd0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (w_irq_act[i]) w_irq_id = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t         <= T_DEPTH'(2);
            r_sd1       <= 1'b0;
            r_sd2       <= 1'b0;
            r_inject    <= 1'b1;
            r_reset_req <= 1'b0;
            r_nmi_req   <= 1'b1;
            r_irq_req   <= 1'b1;
            r_irq_id    <= 3'd0;
            r_nmi_sync  <= '1;
            r_nmi_last  <= 1'b1;
            r_irq_s1    <= '1;
            r_irq_s2    <= '1;
        end else begin
            if (READY) begin
                r_t   <= w_t_nxt;
                r_sd1 <= w_sd1_nxt;
                r_sd2 <= w_sd2_nxt;
                if (w_t0_to_t1) r_inject <= w_pending;
            end

            r_nmi_sync <= {r_nmi_sync[NMI_SYNC-2:0], NMI_n};
            r_nmi_last <= r_nmi_sync[NMI_SYNC-1];
            r_irq_s1   <= IRQ_n;
            r_irq_s2   <= r_irq_s1;

            if (w_ack_rst) r_reset_req <= 1'b1;

            // A fresh edge wins over an acknowledge in the same cycle.
            if (w_nmi_fall)     r_nmi_req <= 1'b0;
            else if (w_ack_nmi) r_nmi_req <= 1'b1;

            r_irq_req <= ~(|w_irq_act) | I_FLAG;
            r_irq_id  <= w_irq_id;
        end
    end

    assign T_state   = r_t;
    assign SD1       = r_sd1;
    assign SD2       = r_sd2;
    assign INJECT    = r_inject;
    assign SYNC      = r_t[1] & ~r_inject;
    assign RESET_req = r_reset_req;
    assign NMI_req   = r_nmi_req;
    assign IRQ_req   = r_irq_req;
    assign IRQ_ID    = r_irq_id;

endmodule

// File: tb/tb_t_sequencer_6502.sv
// tb/tb_t_sequencer_6502.sv - directed self-checking bench for t_sequencer_6502
module tb_t_sequencer_6502;

    logic       clk = 1'b0;
    logic       rst;
    logic       READY;
    logic       NEXT_T;
    logic       CLEAR_T;
    logic       I_FLAG;
    logic       NMI_n;
    logic [3:0] IRQ_n;
    logic [3:0] IRQ_EN;
    logic       VEC_ACK;
    logic [5:0] T_state;
    logic       SD1;
    logic       SD2;
    logic       SYNC;
    logic       INJECT;
    logic       RESET_req;
    logic       NMI_req;
    logic       IRQ_req;
    logic [2:0] IRQ_ID;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] T0 = 6'b000001;
    localparam logic [5:0] T1 = 6'b000010;
    localparam logic [5:0] T2 = 6'b000100;
    localparam logic [5:0] T3 = 6'b001000;
    localparam logic [5:0] T4 = 6'b010000;
    localparam logic [5:0] T5 = 6'b100000;
    localparam logic [5:0] TZ = 6'b000000;

    t_sequencer_6502 #(.T_DEPTH(6), .IRQ_CH(4), .NMI_SYNC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .READY     (READY),
        .NEXT_T    (NEXT_T),
        .CLEAR_T   (CLEAR_T),
        .I_FLAG    (I_FLAG),
        .NMI_n     (NMI_n),
        .IRQ_n     (IRQ_n),
        .IRQ_EN    (IRQ_EN),
        .VEC_ACK   (VEC_ACK),
        .T_state   (T_state),
        .SD1       (SD1),
        .SD2       (SD2),
        .SYNC      (SYNC),
        .INJECT    (INJECT),
        .RESET_req (RESET_req),
        .NMI_req   (NMI_req),
        .IRQ_req   (IRQ_req),
        .IRQ_ID    (IRQ_ID)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [5:0] t, input logic s1, input logic s2);
        check({tag, ".T"},   32'(T_state), 32'(t));
        check({tag, ".SD1"}, 32'(SD1), 32'(s1));
        check({tag, ".SD2"}, 32'(SD2), 32'(s2));
    endtask

    logic [5:0] seq_t  [7];
    logic       seq_s1 [7];
    logic       seq_s2 [7];

    initial begin
        seq_t  = '{T2, T3, T4, T5, TZ, TZ, T0};
        seq_s1 = '{0, 0, 0, 0, 1, 0, 0};
        seq_s2 = '{0, 0, 0, 0, 0, 1, 0};

        rst = 1'b1; READY = 1'b0; NEXT_T = 1'b0; CLEAR_T = 1'b0;
        I_FLAG = 1'b1; NMI_n = 1'b1; IRQ_n = 4'hF; IRQ_EN = 4'h0; VEC_ACK = 1'b0;
        step();
        step();

        // Reset state
        check_st("rst", T1, 0, 0);
        check("rst.INJECT", 32'(INJECT), 1);
        check("rst.RESET_req", 32'(RESET_req), 0);
        check("rst.NMI_req", 32'(NMI_req), 1);
        check("rst.IRQ_req", 32'(IRQ_req), 1);
        check("rst.IRQ_ID", 32'(IRQ_ID), 0);
        check("rst.SYNC", 32'(SYNC), 0);

        // Free-running sequence T1..T5, SD1, SD2, T0
        rst = 1'b0;
        READY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_st($sformatf("seq%0d", i), seq_t[i], seq_s1[i], seq_s2[i]);
            check($sformatf("seq%0d.INJECT", i), 32'(INJECT), 1);
            check($sformatf("seq%0d.RESET_req", i), 32'(RESET_req), 0);
        end

        // Acknowledge the reset vector while stalled in T0
        READY = 1'b0; VEC_ACK = 1'b1;
        step();
        VEC_ACK = 1'b0;
        check("ack_rst.RESET_req", 32'(RESET_req), 1);
        check_st("ack_rst", T0, 0, 0);

        // T0->T1 with nothing pending clears INJECT
        READY = 1'b1;
        step();
        check_st("clr_inj", T1, 0, 0);
        check("clr_inj.INJECT", 32'(INJECT), 0);
        check("clr_inj.SYNC", 32'(SYNC), 1);

        // CLEAR_T beats NEXT_T; both ignored in SD1/SD2
        step();
        check_st("ct.T2", T2, 0, 0);
        CLEAR_T = 1'b1; NEXT_T = 1'b1;
        step();
        check_st("ct.SD1", TZ, 1, 0);
        step();
        check_st("ct.SD2", TZ, 0, 1);
        step();
        check_st("ct.T0", T0, 0, 0);
        CLEAR_T = 1'b0; NEXT_T = 1'b0;
        step();
        check_st("ct.T1", T1, 0, 0);
        check("ct.INJECT", 32'(INJECT), 0);

        // NEXT_T in T2, then in T0, then release
        step();
        check_st("nt.T2", T2, 0, 0);
        NEXT_T = 1'b1;
        step();
        check_st("nt.T0a", T0, 0, 0);
        step();
        check_st("nt.T0b", T0, 0, 0);
        NEXT_T = 1'b0;
        step();
        check_st("nt.T1", T1, 0, 0);

        // Stall in T3 with an NMI falling edge arriving during the stall
        step();
        step();
        check_st("stall.T3", T3, 0, 0);
        READY = 1'b0; NMI_n = 1'b0;
        step();
        check_st("stall1", T3, 0, 0);
        check("stall1.NMI_req", 32'(NMI_req), 1);
        step();
        check_st("stall2", T3, 0, 0);
        check("stall2.NMI_req", 32'(NMI_req), 1);
        step();
        check_st("stall3", T3, 0, 0);
        check("stall3.NMI_req", 32'(NMI_req), 0);
        NMI_n = 1'b1;
        READY = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_st("nmi.T0", T0, 0, 0);
        step();
        check_st("nmi.T1", T1, 0, 0);
        check("nmi.INJECT", 32'(INJECT), 1);
        check("nmi.SYNC", 32'(SYNC), 0);
        READY = 1'b0; VEC_ACK = 1'b1;
        step();
        VEC_ACK = 1'b0;
        check("ack_nmi.NMI_req", 32'(NMI_req), 1);
        check("ack_nmi.RESET_req", 32'(RESET_req), 1);

        // IRQ channels: enables 1100, pins 0011 -> channel 2
        IRQ_EN = 4'b1100; IRQ_n = 4'b0011; I_FLAG = 1'b0;
        step();
        step();
        step();
        check("irq.IRQ_req", 32'(IRQ_req), 0);
        check("irq.IRQ_ID", 32'(IRQ_ID), 2);
        I_FLAG = 1'b1;
        step();
        check("irq_mask.IRQ_req", 32'(IRQ_req), 1);
        IRQ_EN = 4'b1111; IRQ_n = 4'b0101; I_FLAG = 1'b0;
        step();
        step();
        step();
        check("irq2.IRQ_req", 32'(IRQ_req), 0);
        check("irq2.IRQ_ID", 32'(IRQ_ID), 1);
        IRQ_n = 4'hF; I_FLAG = 1'b1;
        step();
        step();
        step();
        check("irq_off.IRQ_req", 32'(IRQ_req), 1);

        // Reset pending together with an NMI edge
        rst = 1'b1;
        #2;
        rst = 1'b0;
        NMI_n = 1'b0;
        step();
        step();
        step();
        check("both.RESET_req", 32'(RESET_req), 0);
        check("both.NMI_req", 32'(NMI_req), 0);
        VEC_ACK = 1'b1;
        step();
        VEC_ACK = 1'b0;
        check("ack1.RESET_req", 32'(RESET_req), 1);
        check("ack1.NMI_req", 32'(NMI_req), 0);

        // New NMI edge coincident with the acknowledge keeps NMI pending
        NMI_n = 1'b1;
        step();
        step();
        step();
        NMI_n = 1'b0;
        step();
        step();
        VEC_ACK = 1'b1;
        step();
        VEC_ACK = 1'b0;
        check("ack_edge.NMI_req", 32'(NMI_req), 0);
        step();
        VEC_ACK = 1'b1;
        step();
        check("ack2.NMI_req", 32'(NMI_req), 1);
        step();
        VEC_ACK = 1'b0;
        check("ack_idle.RESET_req", 32'(RESET_req), 1);
        check("ack_idle.NMI_req", 32'(NMI_req), 1);
        check("ack_idle.IRQ_req", 32'(IRQ_req), 1);

        // Asynchronous reset mid-T4
        READY = 1'b1;
        step();
        step();
        step();
        check_st("pre_rst.T4", T4, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_st("async_rst", T1, 0, 0);
        check("async_rst.INJECT", 32'(INJECT), 1);
        check("async_rst.RESET_req", 32'(RESET_req), 0);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
